// File: rtl/dmem_arb_pkg.sv
// Shared encodings and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam logic [1:0] ARB      = 2'd0;
  localparam logic [1:0] LOCKED   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/dmem_rd_pipe.sv
// Per-port read-return register: captures memory read data on a granted read
// and raises a one-cycle valid; data holds until the next granted read.
module dmem_rd_pipe #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  // Stage p1: registered read return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= capture;
      if (capture) rdata_p1 <= rdata_in;
    end
  end

  assign rvalid = vld_p1;
  assign rdata  = rdata_p1;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter (CPU port C, debug/loader port D) for a single-port data memory.
// Optional wait-cycle statistics are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef DMEM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       c_wait_cnt,
  output logic [15:0]       d_wait_cnt,
`endif
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_lock,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

  logic [1:0] state, state_nxt;
  logic       last_owner, owner_nxt;
  logic [7:0] lock_cnt, lock_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB;
      last_owner <= OWN_D;
      lock_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end

  // lock_cnt only advances while C is actually being held off by a locked D.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ARB: begin
        lock_cnt_nxt = '0;
        if (d_gnt && d_lock) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (!d_lock || !d_req) begin
          state_nxt    = ARB;
          lock_cnt_nxt = '0;
        end else if (c_req && d_gnt) begin
          if (lock_cnt == LOCK_LAST) state_nxt = COOLDOWN;
          else                       lock_cnt_nxt = lock_cnt + 8'd1;
        end else begin
          lock_cnt_nxt = '0;
        end
      end
      COOLDOWN: begin
        state_nxt    = ARB;
        lock_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = ARB;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      case (state)
        LOCKED: begin
          if (d_req)      d_gnt = 1'b1;
          else if (c_req) c_gnt = 1'b1;
        end
        COOLDOWN: begin
          if (c_req)      c_gnt = 1'b1;
          else if (d_req) d_gnt = 1'b1;
        end
        default: begin
          if (c_req && d_req) begin
            if (last_owner == OWN_D) c_gnt = 1'b1;
            else                     d_gnt = 1'b1;
          end else if (c_req) begin
            c_gnt = 1'b1;
          end else if (d_req) begin
            d_gnt = 1'b1;
          end
        end
      endcase
    end
  end

  assign owner_nxt = d_gnt ? OWN_D : (c_gnt ? OWN_C : last_owner);
  assign c_stall   = c_req & ~c_gnt;

  // With no grant the memory sees port C's address/data but never a write.
  assign m_we    = (c_gnt & c_we) | (d_gnt & d_we);
  assign m_addr  = d_gnt ? d_addr  : c_addr;
  assign m_wdata = d_gnt ? d_wdata : c_wdata;

  dmem_rd_pipe #(.DATA_W(DATA_W)) u_c_rd (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (c_gnt & ~c_we),
    .rdata_in (m_rdata),
    .rvalid   (c_rvalid),
    .rdata    (c_rdata)
  );

  dmem_rd_pipe #(.DATA_W(DATA_W)) u_d_rd (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (d_gnt & ~d_we),
    .rdata_in (m_rdata),
    .rvalid   (d_rvalid),
    .rdata    (d_rdata)
  );

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      c_wait_cnt <= '0;
      d_wait_cnt <= '0;
    end else begin
      if (c_req && !c_gnt) c_wait_cnt <= sat_inc(c_wait_cnt);
      if (d_req && !d_gnt) d_wait_cnt <= sat_inc(d_wait_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Table-driven bench for dmem_port_arbiter with a read-data scoreboard and
// hand-written lock-limit / lock-release sequences.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, c_gnt, c_stall, c_rvalid;
  logic [5:0]  c_addr;
  logic [15:0] c_wdata, c_rdata;
  logic        d_req, d_lock, d_we, d_gnt, d_rvalid;
  logic [5:0]  d_addr;
  logic [15:0] d_wdata, d_rdata;
  logic        m_we;
  logic [5:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic        stats_clr;
  logic        clr_next;
  logic [15:0] c_wait_cnt, d_wait_cnt;
`endif

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
`ifdef DMEM_ARB_STATS_EN
    .stats_clr(stats_clr), .c_wait_cnt(c_wait_cnt), .d_wait_cnt(d_wait_cnt),
`endif
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Memory stand-in: combinational read, write at the clock edge.
  logic [15:0] mem [64];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (m_we) begin
      mem[m_addr] <= m_wdata;
    end
  end
  assign m_rdata = mem[m_addr];

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [5:0]  caddr;
    logic [15:0] cwd;
    logic        dreq, dlock, dwe;
    logic [5:0]  daddr;
    logic [15:0] dwd;
    logic        ec, ed;
  } vec_t;

  vec_t        tbl [14];
  logic [15:0] ref_mem [64];
  logic [15:0] cq[$];
  logic [15:0] dq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  function automatic vec_t mk(input int rst, creq, cwe, caddr, cwd,
                              input int dreq, dlock, dwe, daddr, dwd, ec, ed);
    vec_t v;
    v.rst = rst[0]; v.creq = creq[0]; v.cwe = cwe[0];
    v.caddr = 6'(caddr); v.cwd = 16'(cwd);
    v.dreq = dreq[0]; v.dlock = dlock[0]; v.dwe = dwe[0];
    v.daddr = 6'(daddr); v.dwd = 16'(dwd);
    v.ec = ec[0]; v.ed = ed[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    logic pc, pd;
    @(negedge clk);
    rst_n = v.rst;
    c_req = v.creq; c_we = v.cwe; c_addr = v.caddr; c_wdata = v.cwd;
    d_req = v.dreq; d_lock = v.dlock; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwd;
`ifdef DMEM_ARB_STATS_EN
    stats_clr = clr_next;
`endif
    #1;
    chk("c_gnt", 32'(c_gnt), 32'(v.ec));
    chk("d_gnt", 32'(d_gnt), 32'(v.ed));
    chk("c_stall", 32'(c_stall), 32'(v.creq & ~v.ec));
    chk("m_we", 32'(m_we), 32'((v.ec & v.cwe) | (v.ed & v.dwe)));
    chk("m_addr", 32'(m_addr), 32'(v.ed ? v.daddr : v.caddr));
    chk("m_wdata", 32'(m_wdata), 32'(v.ed ? v.dwd : v.cwd));
    pc = v.ec & ~v.cwe;
    pd = v.ed & ~v.dwe;
    if (pc) cq.push_back(ref_mem[v.caddr]);
    if (pd) dq.push_back(ref_mem[v.daddr]);
    if (v.ec && v.cwe) ref_mem[v.caddr] = v.cwd;
    if (v.ed && v.dwe) ref_mem[v.daddr] = v.dwd;
    @(posedge clk);
    #1;
    chk("c_rvalid", 32'(c_rvalid), 32'(pc));
    chk("d_rvalid", 32'(d_rvalid), 32'(pd));
    if (pc && cq.size() > 0) chk("c_rdata", 32'(c_rdata), 32'(cq.pop_front()));
    if (pd && dq.size() > 0) chk("d_rdata", 32'(d_rdata), 32'(dq.pop_front()));
    if (!v.rst) begin
      chk("c_rdata_rst", 32'(c_rdata), 32'd0);
      chk("d_rdata_rst", 32'(d_rdata), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h1000 + 16'(i);
    rst_n = 1'b0; mem_init = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 1'b0; clr_next = 1'b0;
`endif
    @(posedge clk);
    #1 mem_init = 1'b0;

    //             rst C:req we addr wdata     D:req lock we addr wdata     gntC gntD
    tbl[0]  = mk(0, 1, 0,  1, 0,          1, 0, 0,  2, 0,          0, 0);
    tbl[1]  = mk(0, 1, 0,  1, 0,          1, 0, 0,  2, 0,          0, 0);
    tbl[2]  = mk(1, 1, 0,  1, 0,          1, 0, 0,  2, 0,          1, 0);
    tbl[3]  = mk(1, 1, 0,  3, 0,          1, 0, 0,  4, 0,          0, 1);
    tbl[4]  = mk(1, 1, 0,  6, 0,          1, 0, 0,  8, 0,          1, 0);
    tbl[5]  = mk(1, 1, 0, 10, 0,          1, 0, 0, 12, 0,          0, 1);
    tbl[6]  = mk(1, 0, 0,  0, 0,          1, 0, 1,  5, 'hBEEF,     0, 1);
    tbl[7]  = mk(1, 1, 0,  5, 0,          0, 0, 0,  0, 0,          1, 0);
    tbl[8]  = mk(1, 0, 0,  0, 0,          1, 0, 0,  7, 0,          0, 1);
    tbl[9]  = mk(1, 1, 1,  7, 'h1234,     0, 0, 0,  0, 0,          1, 0);
    tbl[10] = mk(1, 0, 0,  0, 0,          1, 0, 0,  7, 0,          0, 1);
    tbl[11] = mk(1, 0, 1, 33, 'hA5A5,     0, 0, 1, 34, 'h5A5A,     0, 0);
    tbl[12] = mk(1, 1, 1,  9, 'h5555,     1, 0, 0,  9, 0,          1, 0);
    tbl[13] = mk(1, 0, 0,  0, 0,          1, 0, 0,  9, 0,          0, 1);
    for (int i = 0; i < 14; i++) step(tbl[i]);

    // Lock limit: D locks while C idle, then C waits MAX_LOCK locked cycles.
`ifdef DMEM_ARB_STATS_EN
    clr_next = 1'b1;
`endif
    step(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1));
`ifdef DMEM_ARB_STATS_EN
    clr_next = 1'b0;
`endif
    for (int i = 0; i < 8; i++) step(mk(1, 1, 0, 1, 0, 1, 1, 0, 10 + i, 0, 0, 1));
    step(mk(1, 1, 0, 2, 0, 1, 1, 0, 3, 0, 1, 0));
`ifdef DMEM_ARB_STATS_EN
    chk("c_wait_cnt", 32'(c_wait_cnt), 32'd8);
    chk("d_wait_cnt", 32'(d_wait_cnt), 32'd1);
    clr_next = 1'b1;
`endif
    step(mk(1, 1, 0, 2, 0, 1, 1, 0, 3, 0, 0, 1));
`ifdef DMEM_ARB_STATS_EN
    chk("c_wait_clr", 32'(c_wait_cnt), 32'd0);
    chk("d_wait_clr", 32'(d_wait_cnt), 32'd0);
    clr_next = 1'b0;
`endif
    step(mk(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0));

    // Lock release after three locked cycles; C must win the following tie.
    step(mk(1, 1, 0, 20, 0, 1, 1, 0, 21, 0, 0, 1));
    for (int i = 0; i < 3; i++) step(mk(1, 1, 0, 20, 0, 1, 1, 0, 22 + i, 0, 0, 1));
    step(mk(1, 1, 0, 20, 0, 1, 0, 0, 25, 0, 0, 1));
    step(mk(1, 1, 0, 26, 0, 1, 0, 0, 27, 0, 1, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    chk("cq_empty", 32'(cq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
